cmac_multi_rate_meter: RTL and testbench

CMAC_MULTI_RATE_METER -- requirements
Module: cmac_multi_rate_meter

---
 rtl/cmac_multi_rate_meter_if.sv | 30 +++
 rtl/cmac_multi_rate_meter.sv | 151 +++++++++++++++
 tb/tb_cmac_multi_rate_meter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmac_multi_rate_meter_if.sv
// Bus bundle for cmac_multi_rate_meter: per-channel stat increments and window
// control in, per-channel totals, windowed rates, peaks and status out.
interface cmac_multi_rate_meter_if #(
  parameter int NUM_CH = 4,
  parameter int INC_W  = 3,
  parameter int RATE_W = 32,
  parameter int TOT_W  = 64
);
  logic [NUM_CH*INC_W-1:0]  stat_inc;
  logic [31:0]              win_cfg;
  logic                     win_load;
  logic                     clear;
  logic [NUM_CH*TOT_W-1:0]  cnt_total;
  logic [NUM_CH*RATE_W-1:0] cnt_rate;
  logic [NUM_CH*RATE_W-1:0] rate_peak;
  logic [NUM_CH-1:0]        rate_sat;
  logic [31:0]              win_active;
  logic                     rate_valid;
  logic                     update_strobe;

  modport master (
    output stat_inc, win_cfg, win_load, clear,
    input  cnt_total, cnt_rate, rate_peak, rate_sat, win_active, rate_valid, update_strobe
  );

  modport slave (
    input  stat_inc, win_cfg, win_load, clear,
    output cnt_total, cnt_rate, rate_peak, rate_sat, win_active, rate_valid, update_strobe
  );
endinterface

// File: rtl/cmac_multi_rate_meter.sv
// Multi-channel CMAC statistics meter: saturating running totals plus windowed
// per-channel rates with peak tracking and a deferred window-length reload.
module cmac_multi_rate_meter #(
  parameter int          NUM_CH     = 4,
  parameter int          INC_W      = 3,
  parameter int          RATE_W     = 32,
  parameter int          TOT_W      = 64,
  parameter int unsigned DEF_WINDOW = 32'd322265625
) (
  input  logic                    clk,
  input  logic                    rst,
  cmac_multi_rate_meter_if.slave  bus
);
  localparam logic [31:0] RST_WINDOW = (DEF_WINDOW < 32'd2) ? 32'd2 : 32'(DEF_WINDOW);

  typedef logic [RATE_W:0] rate_ext_t;
  typedef logic [TOT_W:0]  tot_ext_t;

  function automatic logic [31:0] clamp_win(input logic [31:0] v);
    if (v < 32'd2) begin
      clamp_win = 32'd2;
    end else begin
      clamp_win = v;
    end
  endfunction

  logic [31:0]       timer_r;
  logic [31:0]       win_active_r;
  logic [31:0]       pend_win_r;
  logic              pend_flag_r;
  logic              rate_valid_r;
  logic              strobe_r;
  logic [RATE_W-1:0] acc_r   [NUM_CH];
  logic [RATE_W-1:0] rate_r  [NUM_CH];
  logic [RATE_W-1:0] peak_r  [NUM_CH];
  logic [TOT_W-1:0]  total_r [NUM_CH];
  logic [NUM_CH-1:0] sat_seen_r;
  logic [NUM_CH-1:0] rate_sat_r;

  logic              boundary_s;
  logic [INC_W-1:0]  inc_s      [NUM_CH];
  rate_ext_t         acc_sum_s  [NUM_CH];
  tot_ext_t          tot_sum_s  [NUM_CH];
  logic [RATE_W-1:0] acc_next_s [NUM_CH];
  logic [TOT_W-1:0]  tot_next_s [NUM_CH];
  logic [NUM_CH-1:0] acc_ov_s;

  assign boundary_s = (timer_r == (win_active_r - 32'd1));

  // Saturating next values for every accumulator and total.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      inc_s[c]     = bus.stat_inc[c*INC_W +: INC_W];
      acc_sum_s[c] = {1'b0, acc_r[c]} + rate_ext_t'(inc_s[c]);
      tot_sum_s[c] = {1'b0, total_r[c]} + tot_ext_t'(inc_s[c]);
      acc_ov_s[c]  = acc_sum_s[c][RATE_W];
      if (acc_sum_s[c][RATE_W]) begin
        acc_next_s[c] = '1;
      end else begin
        acc_next_s[c] = acc_sum_s[c][RATE_W-1:0];
      end
      if (tot_sum_s[c][TOT_W]) begin
        tot_next_s[c] = '1;
      end else begin
        tot_next_s[c] = tot_sum_s[c][TOT_W-1:0];
      end
    end
  end

  // Window timer, counters, rate/peak/sat capture; clear wins over a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r      <= 32'd0;
      rate_valid_r <= 1'b0;
      strobe_r     <= 1'b0;
      sat_seen_r   <= '0;
      rate_sat_r   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_r[c]   <= '0;
        rate_r[c]  <= '0;
        peak_r[c]  <= '0;
        total_r[c] <= '0;
      end
    end else if (bus.clear) begin
      timer_r      <= 32'd0;
      rate_valid_r <= 1'b0;
      strobe_r     <= 1'b0;
      sat_seen_r   <= '0;
      rate_sat_r   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_r[c]   <= '0;
        rate_r[c]  <= '0;
        peak_r[c]  <= '0;
        total_r[c] <= '0;
      end
    end else begin
      strobe_r <= boundary_s;
      if (boundary_s) begin
        timer_r      <= 32'd0;
        rate_valid_r <= 1'b1;
      end else begin
        timer_r <= timer_r + 32'd1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        total_r[c] <= tot_next_s[c];
        if (boundary_s) begin
          rate_r[c]     <= acc_next_s[c];
          rate_sat_r[c] <= sat_seen_r[c] | acc_ov_s[c];
          if (acc_next_s[c] > peak_r[c]) begin
            peak_r[c] <= acc_next_s[c];
          end
          acc_r[c]      <= '0;
          sat_seen_r[c] <= 1'b0;
        end else begin
          acc_r[c]      <= acc_next_s[c];
          sat_seen_r[c] <= sat_seen_r[c] | acc_ov_s[c];
        end
      end
    end
  end

  // Window length: loads are held pending and only applied at a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_active_r <= RST_WINDOW;
      pend_win_r   <= 32'd0;
      pend_flag_r  <= 1'b0;
    end else if (boundary_s && !bus.clear) begin
      if (bus.win_load) begin
        win_active_r <= clamp_win(bus.win_cfg);
      end else if (pend_flag_r) begin
        win_active_r <= pend_win_r;
      end
      pend_flag_r <= 1'b0;
    end else if (bus.win_load) begin
      pend_win_r  <= clamp_win(bus.win_cfg);
      pend_flag_r <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.cnt_total[g*TOT_W +: TOT_W]  = total_r[g];
    assign bus.cnt_rate[g*RATE_W +: RATE_W] = rate_r[g];
    assign bus.rate_peak[g*RATE_W +: RATE_W] = peak_r[g];
  end

  assign bus.rate_sat      = rate_sat_r;
  assign bus.win_active    = win_active_r;
  assign bus.rate_valid    = rate_valid_r;
  assign bus.update_strobe = strobe_r;
endmodule

// File: tb/tb_cmac_multi_rate_meter.sv
// Scoreboard bench for cmac_multi_rate_meter: a cycle model predicts each window
// close, queues the expected update and compares it when the strobe appears.
module tb_cmac_multi_rate_meter;
  localparam int NC = 4;
  localparam int IW = 3;
  localparam int RW = 4;
  localparam int TW = 16;
  localparam int DW = 10;
  localparam int RMAX = 15;
  localparam int TMAX = 65535;

  typedef struct packed {
    logic [NC*RW-1:0] rate;
    logic [NC*RW-1:0] peak;
    logic [NC-1:0]    sat;
    logic [31:0]      win;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmac_multi_rate_meter_if #(.NUM_CH(NC), .INC_W(IW), .RATE_W(RW), .TOT_W(TW)) ifc ();

  cmac_multi_rate_meter #(
    .NUM_CH(NC), .INC_W(IW), .RATE_W(RW), .TOT_W(TW), .DEF_WINDOW(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  int m_timer, m_win, m_pend;
  bit m_pflag, m_valid;
  int m_acc[NC], m_rate[NC], m_peak[NC], m_total[NC];
  bit m_satseen[NC], m_rsat[NC];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int clampw(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    m_timer = 0; m_win = clampw(DW); m_pend = 0; m_pflag = 0; m_valid = 0;
    for (int c = 0; c < NC; c++) begin
      m_acc[c] = 0; m_rate[c] = 0; m_peak[c] = 0; m_total[c] = 0;
      m_satseen[c] = 0; m_rsat[c] = 0;
    end
    sb_q.delete();
  endtask

  function automatic exp_t snap();
    exp_t e;
    for (int c = 0; c < NC; c++) begin
      e.rate[c*RW +: RW] = RW'(m_rate[c]);
      e.peak[c*RW +: RW] = RW'(m_peak[c]);
      e.sat[c]           = m_rsat[c];
    end
    e.win = 32'(m_win);
    return e;
  endfunction

  task automatic compare_cycle();
    exp_t e;
    check_val("update_strobe", 64'(ifc.update_strobe), 64'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (ifc.update_strobe) begin
        check_val("cnt_rate", 64'(ifc.cnt_rate), 64'(e.rate));
        check_val("rate_peak", 64'(ifc.rate_peak), 64'(e.peak));
        check_val("rate_sat", 64'(ifc.rate_sat), 64'(e.sat));
        check_val("win_active", 64'(ifc.win_active), 64'(e.win));
      end
    end
    for (int c = 0; c < NC; c++)
      check_val("cnt_total", 64'(ifc.cnt_total[c*TW +: TW]), 64'(m_total[c]));
    check_val("rate_valid", 64'(ifc.rate_valid), 64'(m_valid));
  endtask

  task automatic step(input logic [NC*IW-1:0] incv, input bit ld, input int cfg, input bit clr);
    bit bnd, ov;
    int s, inc;
    ifc.stat_inc = incv; ifc.win_load = ld; ifc.win_cfg = 32'(cfg); ifc.clear = clr;
    bnd = (m_timer == m_win - 1);
    if (clr) begin
      m_timer = 0; m_valid = 0;
      for (int c = 0; c < NC; c++) begin
        m_acc[c] = 0; m_rate[c] = 0; m_peak[c] = 0; m_total[c] = 0;
        m_satseen[c] = 0; m_rsat[c] = 0;
      end
      if (ld) begin m_pend = clampw(cfg); m_pflag = 1; end
    end else begin
      for (int c = 0; c < NC; c++) begin
        inc = int'(incv[c*IW +: IW]);
        s = m_acc[c] + inc;
        ov = (s > RMAX);
        if (ov) s = RMAX;
        m_total[c] = (m_total[c] + inc > TMAX) ? TMAX : m_total[c] + inc;
        if (bnd) begin
          m_rate[c] = s;
          m_rsat[c] = m_satseen[c] | ov;
          if (s > m_peak[c]) m_peak[c] = s;
          m_acc[c] = 0; m_satseen[c] = 0;
        end else begin
          m_acc[c] = s; m_satseen[c] = m_satseen[c] | ov;
        end
      end
      if (bnd) begin
        m_valid = 1; m_timer = 0;
        if (ld) m_win = clampw(cfg);
        else if (m_pflag) m_win = m_pend;
        m_pflag = 0;
        sb_q.push_back(snap());
      end else begin
        m_timer++;
        if (ld) begin m_pend = clampw(cfg); m_pflag = 1; end
      end
    end
    @(posedge clk); #1;
    compare_cycle();
  endtask

  task automatic idle_step();
    step('0, 1'b0, 0, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_rate"}, 64'(ifc.cnt_rate), 64'd0);
    check_val({tag, "_peak"}, 64'(ifc.rate_peak), 64'd0);
    check_val({tag, "_sat"}, 64'(ifc.rate_sat), 64'd0);
    check_val({tag, "_total"}, 64'(ifc.cnt_total), 64'd0);
    check_val({tag, "_valid"}, 64'(ifc.rate_valid), 64'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ifc.stat_inc = {NC{3'd7}}; ifc.clear = 1'b1; ifc.win_load = 1'b1; ifc.win_cfg = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    check_val("reset_strobe", 64'(ifc.update_strobe), 64'd0);
    check_val("reset_win", 64'(ifc.win_active), 64'd10);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [NC*IW-1:0] v;
    apply_reset();

    // ch0=1 every cycle, ch1=3 on cycles 0 and 5
    for (int i = 0; i < 10; i++)
      step({3'd0, 3'd0, ((i == 0 || i == 5) ? 3'd3 : 3'd0), 3'd1}, 1'b0, 0, 1'b0);
    check_val("first_rate0", 64'(ifc.cnt_rate[3:0]), 64'd10);
    check_val("first_rate1", 64'(ifc.cnt_rate[7:4]), 64'd6);
    check_val("first_peak0", 64'(ifc.rate_peak[3:0]), 64'd10);
    check_val("first_peak1", 64'(ifc.rate_peak[7:4]), 64'd6);
    check_val("first_total0", 64'(ifc.cnt_total[15:0]), 64'd10);
    check_val("first_valid", 64'(ifc.rate_valid), 64'd1);

    // ch2 saturates its 4-bit window accumulator
    for (int i = 0; i < 10; i++) step({3'd0, 3'd7, 3'd0, 3'd1}, 1'b0, 0, 1'b0);
    check_val("sat_rate2", 64'(ifc.cnt_rate[11:8]), 64'd15);
    check_val("sat_flags", 64'(ifc.rate_sat), 64'b0100);
    check_val("sat_total2", 64'(ifc.cnt_total[47:32]), 64'd70);

    // deferred reload: load 4 mid-window, then 0 (clamped to 2)
    for (int i = 0; i < 10; i++) step({NC{3'd1}}, (i == 3), 4, 1'b0);
    check_val("load4_win", 64'(ifc.win_active), 64'd4);
    for (int i = 0; i < 8; i++) step({NC{3'd2}}, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step({NC{3'd1}}, (i == 1), 0, 1'b0);
    check_val("load0_win", 64'(ifc.win_active), 64'd2);
    for (int i = 0; i < 4; i++) idle_step();
    // load in the boundary cycle takes effect at that boundary
    for (int i = 0; i < 4 && m_timer != m_win - 1; i++) idle_step();
    step('0, 1'b1, 10, 1'b0);
    check_val("bnd_load_win", 64'(ifc.win_active), 64'd10);

    // peak holds 8 while the next window reports 3, after a clear
    step({NC{3'd3}}, 1'b0, 0, 1'b1);
    check_cleared("clear");
    for (int i = 0; i < 10; i++) step({3'd0, 3'd0, 3'd0, (i < 8) ? 3'd1 : 3'd0}, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++) step({3'd0, 3'd0, 3'd0, (i < 3) ? 3'd1 : 3'd0}, 1'b0, 0, 1'b0);
    check_val("peak_hold", 64'(ifc.rate_peak[3:0]), 64'd8);
    check_val("peak_rate", 64'(ifc.cnt_rate[3:0]), 64'd3);

    // increment only in the boundary cycle belongs to the closing window
    for (int i = 0; i < 10; i++)
      step({((m_timer == m_win - 1) ? 3'd5 : 3'd0), 3'd0, 3'd0, 3'd0}, 1'b0, 0, 1'b0);
    check_val("bnd_inc_rate3", 64'(ifc.cnt_rate[15:12]), 64'd5);
    for (int i = 0; i < 10; i++) idle_step();
    check_val("bnd_inc_next3", 64'(ifc.cnt_rate[15:12]), 64'd0);

    // clear coincident with a boundary: no strobe, everything zero
    for (int i = 0; i < 9; i++) step({NC{3'd1}}, 1'b0, 0, 1'b0);
    step({NC{3'd4}}, 1'b0, 0, 1'b1);
    check_cleared("bnd_clear");
    idle_step();

    // random traffic with occasional reloads
    for (int i = 0; i < 60; i++) begin
      v = NC*IW'($urandom);
      step(v, ($urandom_range(0, 15) == 0), int'($urandom_range(0, 6)), 1'b0);
    end

    // long run at max increment: totals must pin at all-ones, never wrap
    for (int i = 0; i < 9400; i++) step({NC{3'd7}}, 1'b0, 0, 1'b0);
    check_val("total_sat", 64'(ifc.cnt_total), 64'hFFFF_FFFF_FFFF_FFFF);

    // reset mid-stream restores the default window
    apply_reset();
    for (int i = 0; i < 10; i++) step({NC{3'd2}}, 1'b0, 0, 1'b0);
    check_val("post_reset_rate", 64'(ifc.cnt_rate), 64'h0000_0000_0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
